// File: rtl/mem_wb_stage.sv
// MEM stage data memory plus MEM/WB pipeline register with write-back mux,
// sticky misalignment flag and saturating load/store event counters.
module mem_wb_stage #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      result_in,
  input  logic [31:0]      busB_in,
  input  logic [4:0]       Rw_in,
  input  logic             MemtoReg_in,
  input  logic             RegWr_in,
  input  logic             MemWr_in,
  input  logic             stall,
  output logic [31:0]      alu_out,
  output logic [31:0]      mem_out,
  output logic [4:0]       Rw_out,
  output logic             MemtoReg_out,
  output logic             RegWr_out,
  output logic [31:0]      wb_data,
  output logic             align_err,
  output logic [CNT_W-1:0] load_cnt,
  output logic [CNT_W-1:0] store_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       mem [DEPTH];
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       rd_word;
  logic              is_access;
  logic              misaligned;
  logic              advance;
  logic              do_store;
  logic              do_load_cnt;
  logic              do_store_cnt;
  logic              unused_addr_bits;

  // Upper address bits alias onto the same words.
  assign word_idx         = result_in[ADDR_W+1:2];
  assign unused_addr_bits = ^{result_in[31:ADDR_W+2]};

  assign rd_word    = mem[word_idx];
  assign is_access  = MemWr_in | MemtoReg_in;
  assign misaligned = is_access && (result_in[1:0] != 2'b00);

  assign advance      = !rst && !stall;
  assign do_store     = advance && MemWr_in && !misaligned;
  assign do_load_cnt  = advance && MemtoReg_in && !misaligned;
  assign do_store_cnt = do_store;

  // Contents survive reset; only reset/stall/misalignment block a write.
  always_ff @(negedge clk) begin
    if (do_store) begin
      mem[word_idx] <= busB_in;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      alu_out      <= '0;
      mem_out      <= '0;
      Rw_out       <= '0;
      MemtoReg_out <= 1'b0;
      RegWr_out    <= 1'b0;
    end else if (!stall) begin
      alu_out      <= result_in;
      mem_out      <= rd_word;
      Rw_out       <= Rw_in;
      MemtoReg_out <= MemtoReg_in;
      RegWr_out    <= RegWr_in && (Rw_in != 5'd0) && !misaligned;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      align_err <= 1'b0;
    end else if (advance && misaligned) begin
      align_err <= 1'b1;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(negedge clk) begin
    if (rst) begin
      load_cnt  <= '0;
      store_cnt <= '0;
    end else begin
      if (do_load_cnt && (load_cnt != '1)) begin
        load_cnt <= load_cnt + CNT_W'(1);
      end
      if (do_store_cnt && (store_cnt != '1)) begin
        store_cnt <= store_cnt + CNT_W'(1);
      end
    end
  end

  assign wb_data = MemtoReg_out ? mem_out : alu_out;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: the driver queues hand-computed MEM/WB
// results per falling edge, a monitor pops and compares them on the rising edge.
module tb_mem_wb_stage;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             rst;
  logic [31:0]      result_in;
  logic [31:0]      busB_in;
  logic [4:0]       Rw_in;
  logic             MemtoReg_in;
  logic             RegWr_in;
  logic             MemWr_in;
  logic             stall;
  logic [31:0]      alu_out;
  logic [31:0]      mem_out;
  logic [4:0]       Rw_out;
  logic             MemtoReg_out;
  logic             RegWr_out;
  logic [31:0]      wb_data;
  logic             align_err;
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] store_cnt;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] mem;
    logic [4:0]  rw;
    logic        m2r;
    logic        regwr;
    logic [31:0] wb;
    logic        aerr;
    logic [31:0] lcnt;
    logic [31:0] scnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  mem_wb_stage #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .result_in(result_in), .busB_in(busB_in),
    .Rw_in(Rw_in), .MemtoReg_in(MemtoReg_in), .RegWr_in(RegWr_in),
    .MemWr_in(MemWr_in), .stall(stall), .alu_out(alu_out), .mem_out(mem_out),
    .Rw_out(Rw_out), .MemtoReg_out(MemtoReg_out), .RegWr_out(RegWr_out),
    .wb_data(wb_data), .align_err(align_err), .load_cnt(load_cnt),
    .store_cnt(store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // DUT state settles on the falling edge; compare mid-cycle on the rising edge.
  always @(posedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checkOutput("alu_out",      alu_out,                 e.alu);
      checkOutput("mem_out",      mem_out,                 e.mem);
      checkOutput("Rw_out",       {27'd0, Rw_out},         {27'd0, e.rw});
      checkOutput("MemtoReg_out", {31'd0, MemtoReg_out},   {31'd0, e.m2r});
      checkOutput("RegWr_out",    {31'd0, RegWr_out},      {31'd0, e.regwr});
      checkOutput("wb_data",      wb_data,                 e.wb);
      checkOutput("align_err",    {31'd0, align_err},      {31'd0, e.aerr});
      checkOutput("load_cnt",     32'(load_cnt),           e.lcnt);
      checkOutput("store_cnt",    32'(store_cnt),          e.scnt);
    end
  end

  task automatic applyStimulus(
    input logic r, input logic st, input logic [31:0] res, input logic [31:0] bb,
    input logic [4:0] rw, input logic m2r, input logic rg, input logic mw,
    input logic [31:0] e_alu, input logic [31:0] e_mem, input logic [4:0] e_rw,
    input logic e_m2r, input logic e_rg, input logic [31:0] e_wb, input logic e_aerr,
    input int e_l, input int e_s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; stall = st; result_in = res; busB_in = bb;
    Rw_in = rw; MemtoReg_in = m2r; RegWr_in = rg; MemWr_in = mw;
    e.alu = e_alu; e.mem = e_mem; e.rw = e_rw; e.m2r = e_m2r; e.regwr = e_rg;
    e.wb = e_wb; e.aerr = e_aerr; e.lcnt = 32'(e_l); e.scnt = 32'(e_s);
    exp_q.push_back(e);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; result_in = '0; busB_in = '0;
    Rw_in = '0; MemtoReg_in = 1'b0; RegWr_in = 1'b0; MemWr_in = 1'b0;

    // reset edge with a store pending at 0x30: store must be dropped
    applyStimulus(1,0, 32'h30, 32'h99, 3,0,1,1,  32'h0, 32'h0, 0,0,0, 32'h0, 0, 0,0);
    // store/load pair
    applyStimulus(0,0, 32'h10, 32'hDEADBEEF, 0,0,0,1,  32'h10, 32'h0, 0,0,0, 32'h10, 0, 0,1);
    applyStimulus(0,0, 32'h10, 32'h0, 5,1,1,0,  32'h10, 32'hDEADBEEF, 5,1,1, 32'hDEADBEEF, 0, 1,1);
    // wrap-around aliasing
    applyStimulus(0,0, 32'h4, 32'h11111111, 0,0,0,1,  32'h4, 32'h0, 0,0,0, 32'h4, 0, 1,2);
    applyStimulus(0,0, 32'h404, 32'h0, 1,1,1,0,  32'h404, 32'h11111111, 1,1,1, 32'h11111111, 0, 2,2);
    applyStimulus(0,0, 32'h30, 32'h0, 2,1,1,0,  32'h30, 32'h0, 2,1,1, 32'h0, 0, 3,2);
    // stalls hold everything, including a misaligned access
    applyStimulus(0,1, 32'h20, 32'h5A5A5A5A, 0,0,0,1,  32'h30, 32'h0, 2,1,1, 32'h0, 0, 3,2);
    applyStimulus(0,1, 32'h20, 32'h5A5A5A5A, 0,0,0,1,  32'h30, 32'h0, 2,1,1, 32'h0, 0, 3,2);
    applyStimulus(0,1, 32'h22, 32'h0, 6,1,1,0,  32'h30, 32'h0, 2,1,1, 32'h0, 0, 3,2);
    applyStimulus(0,0, 32'h20, 32'h0, 4,1,1,0,  32'h20, 32'h0, 4,1,1, 32'h0, 0, 4,2);
    // ALU results and r0 write suppression
    applyStimulus(0,0, 32'h7, 32'h0, 0,0,1,0,  32'h7, 32'h11111111, 0,0,0, 32'h7, 0, 4,2);
    applyStimulus(0,0, 32'h7, 32'h0, 3,0,1,0,  32'h7, 32'h11111111, 3,0,1, 32'h7, 0, 4,2);
    // misaligned load, then sticky flag over three aligned edges
    applyStimulus(0,0, 32'h22, 32'h0, 6,1,1,0,  32'h22, 32'h0, 6,1,0, 32'h0, 1, 4,2);
    applyStimulus(0,0, 32'h100, 32'h0, 7,0,1,0,  32'h100, 32'h0, 7,0,1, 32'h100, 1, 4,2);
    applyStimulus(0,0, 32'h200, 32'h0, 7,0,1,0,  32'h200, 32'h0, 7,0,1, 32'h200, 1, 4,2);
    applyStimulus(0,0, 32'h300, 32'h0, 7,0,1,0,  32'h300, 32'h0, 7,0,1, 32'h300, 1, 4,2);
    // misaligned store must not write or count
    applyStimulus(0,0, 32'h13, 32'hFFFFFFFF, 0,0,0,1,  32'h13, 32'hDEADBEEF, 0,0,0, 32'h13, 1, 4,2);
    // combined store+load returns old word, bumps both counters
    applyStimulus(0,0, 32'h40, 32'hCAFEF00D, 8,1,1,1,  32'h40, 32'h0, 8,1,1, 32'h0, 1, 5,3);
    applyStimulus(0,0, 32'h40, 32'h0, 9,1,1,0,  32'h40, 32'hCAFEF00D, 9,1,1, 32'hCAFEF00D, 1, 6,3);
    // reset overrides stall and drops the in-flight store
    applyStimulus(1,1, 32'h10, 32'h12345678, 5,1,1,1,  32'h0, 32'h0, 0,0,0, 32'h0, 0, 0,0);
    applyStimulus(0,0, 32'h10, 32'h0, 5,1,1,0,  32'h10, 32'hDEADBEEF, 5,1,1, 32'hDEADBEEF, 0, 1,0);
    // counter saturation at 4'hF
    for (int i = 0; i < 16; i++) begin
      applyStimulus(0,0, 32'h44, 32'(i), 1,1,1,1,
                    32'h44, (i == 0) ? 32'h0 : 32'(i-1), 1,1,1,
                    (i == 0) ? 32'h0 : 32'(i-1), 0,
                    (i + 2 > 15) ? 15 : i + 2, (i + 1 > 15) ? 15 : i + 1);
    end
    applyStimulus(0,0, 32'h44, 32'h0, 1,1,1,0,  32'h44, 32'hF, 1,1,1, 32'hF, 0, 15,15);

    @(posedge clk);
    #1;
    rst = 1'b0; stall = 1'b1; MemWr_in = 1'b0; MemtoReg_in = 1'b0;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
